dmem_bridge: RTL and testbench

Data-memory bridge between the core's MEM stage RAM interface and the SoC data bus. Converts each load/store into a byte-lane-aligned bus transaction with a valid/ready request channel and a separate read-return channel. Performs RV32I sub-word extraction and sign/zero extension, and stalls the pipeline until the access completes. Detects misaligned accesses and bus timeouts.

---
 rtl/dmem_bridge_if.sv | 22 ++
 rtl/dmem_bridge.sv | 141 ++++++++++++++
 tb/tb_dmem_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
// Data-bus side of dmem_bridge: valid/ready request channel plus read-return channel.
// The bridge drives the request fields through the master modport. The SoC bus uses the slave modport.
interface dmem_bridge_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata, bus_rvalid
  );
endinterface

// File: rtl/dmem_bridge.sv
// MEM-stage to SoC data-bus bridge: lane-aligned requests, RV32I load extension,
// pipeline stall generation, misalignment detection and bus timeout.
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_re,
  input  logic          mem_we,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic [2:0]    func3,
  output logic          stall,
  output logic [31:0]   load_data,
  output logic          misalign_err,
  output logic          bus_err,
  dmem_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        req;
  logic        is_byte;
  logic        is_half;
  logic        aligned;
  logic        accept;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] rd_b_sh;
  logic [31:0] rd_h_sh;
  logic [31:0] ld_next;

  always_comb begin
    req     = mem_re | mem_we;
    is_byte = (func3 == 3'b000) || (func3 == 3'b100);
    is_half = (func3 == 3'b001) || (func3 == 3'b101);
    aligned = is_byte || (is_half && !addr[0]) || (addr[1:0] == 2'b00);
    accept  = (state == IDLE) && req && aligned;

    stall        = accept || (state == REQ) || (state == WAIT_R);
    misalign_err = (state == IDLE) && req && !aligned;
  end

  // Store lane placement; the width decode is shared with loads, so unused codes act as W
  always_comb begin
    st_strb = 4'hF;
    st_data = wdata;
    if (is_byte) begin
      st_strb = 4'b0001 << addr[1:0];
      st_data = {4{wdata[7:0]}};
    end else if (is_half) begin
      st_strb = addr[1] ? 4'b1100 : 4'b0011;
      st_data = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    rd_b_sh = bus.bus_rdata >> {off_q, 3'b000};
    rd_h_sh = bus.bus_rdata >> {off_q[1], 4'b0000};
    case (f3_q)
      3'b000:  ld_next = {{24{rd_b_sh[7]}}, rd_b_sh[7:0]};
      3'b100:  ld_next = {24'h0, rd_b_sh[7:0]};
      3'b001:  ld_next = {{16{rd_h_sh[15]}}, rd_h_sh[15:0]};
      3'b101:  ld_next = {16'h0, rd_h_sh[15:0]};
      default: ld_next = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      bus.bus_valid <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_wstrb <= '0;
      load_data     <= '0;
      bus_err       <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus.bus_valid <= 1'b1;
            bus.bus_we    <= mem_we;
            bus.bus_addr  <= {addr[31:2], 2'b00};
            bus.bus_wdata <= mem_we ? st_data : wdata;
            bus.bus_wstrb <= mem_we ? st_strb : 4'hF;
            f3_q          <= func3;
            off_q         <= addr[1:0];
            cnt           <= '0;
            state         <= REQ;
          end
        end
        REQ: begin
          // A write handshake completes the access; a read handshake on the last budget cycle still times out
          if (bus.bus_ready && bus.bus_we) begin
            bus.bus_valid <= 1'b0;
            state         <= DONE;
          end else if (cnt == CNT_LAST) begin
            bus.bus_valid <= 1'b0;
            load_data     <= '0;
            bus_err       <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
            if (bus.bus_ready) begin
              bus.bus_valid <= 1'b0;
              state         <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (bus.bus_rvalid) begin
            load_data <= ld_next;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            load_data <= '0;
            bus_err   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed vector table, reset sequences and randomized
// accesses checked against an arithmetic reference model.
module tb_dmem_bridge;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  func3 = '0;
  logic        stall;
  logic [31:0] load_data;
  logic        misalign_err;
  logic        bus_err;

  dmem_bridge_if bif();

  dmem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_re(mem_re), .mem_we(mem_we),
    .addr(addr), .wdata(wdata), .func3(func3), .stall(stall),
    .load_data(load_data), .misalign_err(misalign_err), .bus_err(bus_err),
    .bus(bif.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          stall;
    int          mis_cnt;
    int          berr_cnt;
    logic [31:0] ld;
    logic        saw_valid, unstable, valid_late, valid_at_done, stall_after, hung;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
  } obs_t;

  typedef struct {
    int          stall;
    logic [31:0] ld;
    logic        mis, berr, valid, we;
    logic [31:0] baddr, wd;
    logic [3:0]  strb;
  } exp_t;

  typedef struct {
    logic        we, re;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd;
    int          rdy, rv;
    int          e_stall;
    logic [31:0] e_ld;
    logic        e_mis, e_berr;
    logic [31:0] e_wd;
    logic [3:0]  e_strb;
  } vec_t;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called just after a rising edge; drives one MEM-stage request and plays the bus side
  task automatic run_access(input logic we, input logic re, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                            input int rdy, input int rv, output obs_t o);
    bit hs;
    bit done;
    int rq;
    int rw;
    o = '{default: '0};
    hs = 0; done = 0; rq = 0; rw = 0;
    mem_we = we; mem_re = re; func3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (hs && !we) begin
        bif.bus_rvalid = (rw >= rv);
        bif.bus_rdata  = (rw >= rv) ? rd : ~rd;
        rw++;
      end else begin
        bif.bus_rvalid = !hs;
        bif.bus_rdata  = ~rd;
      end
      if (bif.bus_valid && !hs) begin
        if (!o.saw_valid) begin
          o.saw_valid = 1'b1;
          o.we = bif.bus_we; o.addr = bif.bus_addr; o.wdata = bif.bus_wdata; o.strb = bif.bus_wstrb;
        end else if ({bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_wstrb} !=
                     {o.we, o.addr, o.wdata, o.strb}) begin
          o.unstable = 1'b1;
        end
        bif.bus_ready = (rq >= rdy);
        rq++;
        if (bif.bus_ready) hs = 1;
      end else begin
        if (bif.bus_valid) o.valid_late = 1'b1;
        bif.bus_ready = 1'b0;
      end
      o.mis_cnt  += int'(misalign_err);
      o.berr_cnt += int'(bus_err);
      if (stall) o.stall++;
      else begin
        done = 1;
        o.ld = load_data;
        o.valid_at_done = bif.bus_valid;
      end
    end
    o.hung = !done;
    @(posedge clk); #1;
    mem_re = 1'b0; mem_we = 1'b0; bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0;
    @(negedge clk);
    o.mis_cnt  += int'(misalign_err);
    o.berr_cnt += int'(bus_err);
    o.stall_after = stall;
    @(posedge clk); #1;
  endtask

  task automatic check_access(input string t, input obs_t o, input exp_t e);
    chk1 ({t, " hung"}, o.hung, 1'b0);
    chk32({t, " stall_cycles"}, 32'(o.stall), 32'(e.stall));
    chk32({t, " load_data"}, o.ld, e.ld);
    chk32({t, " misalign_pulses"}, 32'(o.mis_cnt), 32'(e.mis));
    chk32({t, " bus_err_pulses"}, 32'(o.berr_cnt), 32'(e.berr));
    chk1 ({t, " bus_valid_seen"}, o.saw_valid, e.valid);
    chk1 ({t, " valid_after_hs"}, o.valid_late | o.valid_at_done, 1'b0);
    chk1 ({t, " stall_after"}, o.stall_after, 1'b0);
    if (e.valid) begin
      chk32({t, " bus_addr"}, o.addr, e.baddr);
      chk32({t, " bus_wstrb"}, 32'(o.strb), 32'(e.strb));
      chk1 ({t, " bus_we"}, o.we, e.we);
      chk1 ({t, " req_stable"}, o.unstable, 1'b0);
      if (e.we) chk32({t, " bus_wdata"}, o.wdata, e.wd);
    end
  endtask

  // Reference: access rules expressed as sizes, byte offsets and cycle budgets
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int rdy, input int rv, input logic [31:0] prev);
    exp_t e;
    int unsigned sz;
    int unsigned off;
    int unsigned bus_cyc;
    logic [31:0] v;
    sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    off = a % 4;
    e = '{default: '0};
    e.ld = prev; e.we = we; e.baddr = a - off; e.strb = 4'hF;
    if (a % sz != 0) begin
      e.mis = 1'b1;
      return e;
    end
    e.valid = 1'b1;
    if (we) begin
      e.strb = (sz == 4) ? 4'hF : (sz == 2) ? 4'(4'h3 << off) : 4'(4'h1 << off);
      e.wd   = (sz == 4) ? wd : (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd[7:0] * 32'h0101_0101;
      bus_cyc = rdy + 1;
    end else begin
      bus_cyc = rdy + 1 + rv + 1;
    end
    if (bus_cyc > TO) begin
      e.stall = 1 + TO; e.berr = 1'b1; e.ld = '0;
    end else begin
      e.stall = 1 + bus_cyc;
      if (!we) begin
        v = rd >> (8 * off);
        if (sz == 1) begin
          v = v & 32'hFF;
          if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (sz == 2) begin
          v = v & 32'hFFFF;
          if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end
        e.ld = v;
      end
    end
    return e;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[22];
    obs_t        o;
    exp_t        e;
    logic [31:0] prev_ld;
    logic        rwe, rre;
    logic [2:0]  rf3;
    logic [31:0] ra, rwd, rrd;
    int          rrdy, rrv;

    vecs = '{
      '{1'b0, 1'b1, 3'b000, 32'h103, 32'h0,         32'h80AB_CDEF, 0,   0,   3,  32'hFFFF_FF80, 1'b0, 1'b0, 32'h0,         4'hF},
      '{1'b0, 1'b1, 3'b101, 32'h202, 32'h0,         32'h9234_5678, 0,   0,   3,  32'h0000_9234, 1'b0, 1'b0, 32'h0,         4'hF},
      '{1'b0, 1'b1, 3'b001, 32'h202, 32'h0,         32'h9234_5678, 0,   0,   3,  32'hFFFF_9234, 1'b0, 1'b0, 32'h0,         4'hF},
      '{1'b1, 1'b0, 3'b001, 32'h302, 32'h1111_BEEF, 32'h0,         3,   0,   5,  32'hFFFF_9234, 1'b0, 1'b0, 32'hBEEF_BEEF, 4'hC},
      '{1'b0, 1'b1, 3'b010, 32'h401, 32'h0,         32'h0,         0,   0,   0,  32'hFFFF_9234, 1'b1, 1'b0, 32'h0,         4'hF},
      '{1'b1, 1'b0, 3'b001, 32'h003, 32'h1234_5678, 32'h0,         0,   0,   0,  32'hFFFF_9234, 1'b1, 1'b0, 32'h0,         4'hF},
      '{1'b0, 1'b1, 3'b010, 32'h400, 32'h0,         32'hDEAD_BEEF, 1,   2,   6,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         4'hF},
      '{1'b0, 1'b1, 3'b000, 32'h500, 32'h0,         32'h55,        100, 0,   17, 32'h0,         1'b0, 1'b1, 32'h0,         4'hF},
      '{1'b0, 1'b1, 3'b010, 32'h404, 32'h0,         32'h1234_5678, 0,   0,   3,  32'h1234_5678, 1'b0, 1'b0, 32'h0,         4'hF},
      '{1'b1, 1'b0, 3'b000, 32'h601, 32'hAABB_CC5A, 32'h0,         0,   0,   2,  32'h1234_5678, 1'b0, 1'b0, 32'h5A5A_5A5A, 4'h2},
      '{1'b0, 1'b1, 3'b100, 32'h702, 32'h0,         32'h11F1_2233, 0,   0,   3,  32'h0000_00F1, 1'b0, 1'b0, 32'h0,         4'hF},
      '{1'b0, 1'b1, 3'b001, 32'h010, 32'h0,         32'h8888_8888, 0,   100, 17, 32'h0,         1'b0, 1'b1, 32'h0,         4'hF},
      '{1'b1, 1'b1, 3'b010, 32'h800, 32'hCAFE_F00D, 32'h0,         0,   0,   2,  32'h0,         1'b0, 1'b0, 32'hCAFE_F00D, 4'hF},
      '{1'b0, 1'b1, 3'b011, 32'h902, 32'h0,         32'h0,         0,   0,   0,  32'h0,         1'b1, 1'b0, 32'h0,         4'hF},
      '{1'b0, 1'b1, 3'b010, 32'hA00, 32'h0,         32'h0BAD_F00D, 7,   7,   17, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0,         4'hF},
      '{1'b0, 1'b1, 3'b101, 32'hA02, 32'h0,         32'h7777_7777, 7,   8,   17, 32'h0,         1'b0, 1'b1, 32'h0,         4'hF},
      '{1'b1, 1'b0, 3'b010, 32'hB00, 32'h0102_0304, 32'h0,         15,  0,   17, 32'h0,         1'b0, 1'b0, 32'h0102_0304, 4'hF},
      '{1'b0, 1'b1, 3'b001, 32'h20E, 32'h0,         32'h7FFF_0000, 0,   0,   3,  32'h0000_7FFF, 1'b0, 1'b0, 32'h0,         4'hF},
      '{1'b1, 1'b0, 3'b010, 32'hB04, 32'h0506_0708, 32'h0,         16,  0,   17, 32'h0,         1'b0, 1'b1, 32'h0506_0708, 4'hF},
      '{1'b0, 1'b1, 3'b000, 32'h101, 32'h0,         32'h0000_7F00, 0,   0,   3,  32'h0000_007F, 1'b0, 1'b0, 32'h0,         4'hF},
      '{1'b1, 1'b0, 3'b001, 32'h102, 32'hFFFF_1234, 32'h0,         0,   0,   2,  32'h0000_007F, 1'b0, 1'b0, 32'h1234_1234, 4'hC},
      '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0000_00A5, 32'h0,         2,   0,   4,  32'h0000_007F, 1'b0, 1'b0, 32'hA5A5_A5A5, 4'h8}
    };

    bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1 ("reset bus_valid", bif.bus_valid, 1'b0);
    chk1 ("reset bus_we", bif.bus_we, 1'b0);
    chk32("reset bus_addr", bif.bus_addr, 32'h0);
    chk32("reset bus_wdata", bif.bus_wdata, 32'h0);
    chk32("reset bus_wstrb", 32'(bif.bus_wstrb), 32'h0);
    chk32("reset load_data", load_data, 32'h0);
    chk1 ("reset bus_err", bus_err, 1'b0);
    chk1 ("reset stall", stall, 1'b0);
    chk1 ("reset misalign_err", misalign_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_access(vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd,
                 vecs[i].rdy, vecs[i].rv, o);
      e = '{default: '0};
      e.stall = vecs[i].e_stall; e.ld = vecs[i].e_ld; e.mis = vecs[i].e_mis; e.berr = vecs[i].e_berr;
      e.valid = !vecs[i].e_mis; e.we = vecs[i].we; e.baddr = {vecs[i].a[31:2], 2'b00};
      e.wd = vecs[i].e_wd; e.strb = vecs[i].e_strb;
      check_access($sformatf("vec%0d", i), o, e);
    end

    // Reset while a request waits for bus_ready: bus_valid must fall without a clock edge
    mem_re = 1'b1; mem_we = 1'b0; func3 = 3'b010; addr = 32'hC00; bif.bus_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("rstA valid_before", bif.bus_valid, 1'b1);
    #2 rst_n = 1'b0; mem_re = 1'b0;
    #1;
    chk1 ("rstA valid_async", bif.bus_valid, 1'b0);
    chk1 ("rstA stall", stall, 1'b0);
    chk32("rstA load_data", load_data, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("rstA valid_after", bif.bus_valid, 1'b0);
    chk1("rstA bus_err_after", bus_err, 1'b0);

    run_access(1'b0, 1'b1, 3'b010, 32'h404, 32'h0, 32'h1234_5678, 0, 0, o);
    chk32("rstB preload", o.ld, 32'h1234_5678);

    // Reset during WAIT_R, then a late rvalid that must be ignored
    mem_re = 1'b1; mem_we = 1'b0; func3 = 3'b000; addr = 32'hD01; bif.bus_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bif.bus_ready = 1'b0;
    chk1("rstB stall_in_wait", stall, 1'b1);
    #2 rst_n = 1'b0; mem_re = 1'b0;
    #1;
    chk32("rstB load_data", load_data, 32'h0);
    chk1 ("rstB valid", bif.bus_valid, 1'b0);
    chk1 ("rstB stall", stall, 1'b0);
    @(negedge clk) begin
      rst_n = 1'b1; bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'hFFFF_FFFF;
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk32($sformatf("rstB late_rvalid load_data c%0d", k), load_data, 32'h0);
      chk1 ($sformatf("rstB late_rvalid stall c%0d", k), stall, 1'b0);
      chk1 ($sformatf("rstB late_rvalid bus_err c%0d", k), bus_err, 1'b0);
    end
    bif.bus_rvalid = 1'b0;
    prev_ld = '0;

    for (int n = 0; n < 150; n++) begin
      rwe  = 1'($urandom % 2);
      rre  = rwe ? 1'($urandom % 2) : 1'b1;
      rf3  = 3'($urandom % 8);
      ra   = $urandom;
      rwd  = $urandom;
      rrd  = $urandom;
      rrdy = ($urandom % 8 == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4));
      rrv  = ($urandom % 8 == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4));
      run_access(rwe, rre, rf3, ra, rwd, rrd, rrdy, rrv, o);
      e = model(rwe, rf3, ra, rwd, rrd, rrdy, rrv, prev_ld);
      check_access($sformatf("rnd%0d", n), o, e);
      prev_ld = e.ld;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
